vc_fifo_bank: RTL
=================

# vc_fifo_bank

Parametrised multi-virtual-channel FIFO bank for the PCIe transmit-layer datapath. Holds NUM_VC independent circular FIFOs behind one shared write port and one shared read port, each addressed by a VC index. Provides per-VC full/empty/almost flags against programmable thresholds and sticky overflow/underflow error reporting. Replaces single-channel VC FIFOs in the arbiter front end.

## Interface
- DATA_WIDTH, 6, word width
- ADDR_WIDTH, 4, per-VC depth is DEPTH = 2**ADDR_WIDTH
- NUM_VC, 2, number of virtual channels (1..8)
- VC_W, 3, VC index width (must satisfy 2**VC_W >= NUM_VC)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- init  in  1  synchronous, active-low soft clear (same effect as reset, sampled on clk)
- wr_enable  in  1  write request
- wr_vc  in  VC_W  target VC of write
- data_in  in  DATA_WIDTH  write data
- rd_enable  in  1  read request
- rd_vc  in  VC_W  source VC of read
- umbral_low  in  NUM_VC*ADDR_WIDTH  per-VC almost-empty threshold, VC i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- umbral_high  in  NUM_VC*ADDR_WIDTH  per-VC almost-full margin, same packing
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  data_out holds a valid word
- full  out  NUM_VC  bit i: cnt_i == DEPTH
- empty  out  NUM_VC  bit i: cnt_i == 0
- almost_full  out  NUM_VC  bit i: cnt_i >= DEPTH - umbral_high_i
- almost_empty  out  NUM_VC  bit i: cnt_i <= umbral_low_i
- overflow  out  NUM_VC  sticky: write attempted to full VC
- underflow  out  NUM_VC  sticky: read attempted from empty VC
- err_clr  in  NUM_VC  write-1-to-clear for overflow/underflow bits

## Operation
- Per VC: wr_ptr, rd_ptr (ADDR_WIDTH, natural wrap DEPTH-1 -> 0), cnt (ADDR_WIDTH+1 bits, 0..DEPTH).
- Write accepted iff wr_enable && wr_vc < NUM_VC && (!full[wr_vc] || read of same VC accepted this cycle). Accepted: mem[wr_vc][wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff rd_enable && rd_vc < NUM_VC && !empty[rd_vc]. Accepted: data_out <= word at rd_ptr, rd_ptr++, data_valid <= 1. Otherwise data_out <= 0, data_valid <= 0.
- cnt update per VC: +1 write-only, -1 read-only, unchanged for both or neither. cnt never leaves 0..DEPTH.
- Rejected write to full VC: data dropped, pointers/cnt unchanged, overflow[vc] set. Rejected read from empty VC: underflow[vc] set, data_valid 0.
- Out-of-range VC index (>= NUM_VC): request ignored, no flag set.
- Error bits: set has priority over err_clr in the same cycle.
- Simultaneous read and write, same VC, empty: read rejected (underflow set), write accepted; no write-through bypass.
- Simultaneous read and write, same VC, full: both accepted, cnt stays DEPTH.
- Threshold flags are combinational from cnt and live threshold inputs; thresholds may change at any time.

## Timing
- Reset (async assert) or init low at clk edge: all pointers 0, cnt 0, data_out 0, data_valid 0, overflow/underflow 0, hence empty all 1, full all 0; almost flags follow thresholds.
- Reset deassertion assumed synchronous to clk externally; first operation on the edge after release.
- Read latency 1 cycle: rd_enable at edge N -> data_out/data_valid valid after edge N, for one cycle.
- Status flags reflect cnt after the last edge (0-cycle combinational from registers).
- Reset mid-operation: contents discarded; memory array need not be cleared.

## Structure
- Shared package/header vc_fifo_pkg: MAX_VC, VC index width helper, default DATA_WIDTH/ADDR_WIDTH.
- Sub-module vc_fifo_channel (one VC: memory, pointers, counter, flags, sticky errors), instantiated NUM_VC times via generate; top handles request decode and output mux/register.

## Test plan
- Reset then fill VC0 with 16 writes (0x01..0x10): full[0]=1 after 16th edge, empty[1] stays 1; 17th write sets overflow[0], cnt stays 16.
- Interleave VC0/VC1 writes (A,B,A,B), read VC1 twice: data_out = B0 then B1, data_valid 1 each cycle, VC0 cnt unaffected.
- Read empty VC1: data_valid 0, data_out 0, underflow[1]=1; err_clr[1]=1 next cycle clears it.
- umbral_low=3, umbral_high=2: almost_empty 1 at cnt 0..3, 0 at 4; almost_full 1 at cnt 14..16.
- Full VC0, simultaneous read+write for 20 cycles: cnt 16 throughout, order preserved across pointer wrap, no overflow.
- Assert reset mid-burst with cnt 7: all flags at reset values immediately; init low likewise clears on next edge.

Source files
------------

// File: rtl/vc_fifo_pkg.sv
// Shared definitions for the multi-VC FIFO bank: VC limit, default
// geometry and a helper that sizes a VC index for a given channel count.
package vc_fifo_pkg;

   localparam int MAX_VC             = 8;
   localparam int DEFAULT_DATA_WIDTH = 6;
   localparam int DEFAULT_ADDR_WIDTH = 4;

   // Smallest index width able to address num_vc channels (at least 1 bit).
   function automatic int vc_index_width(input int num_vc);
      return (num_vc <= 1) ? 1 : $clog2(num_vc);
   endfunction

endpackage

// File: rtl/vc_fifo_channel.sv
// One virtual channel: circular memory, pointers, occupancy counter,
// threshold flags and sticky overflow/underflow bits.
module vc_fifo_channel
   import vc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic                  wr_req,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] umbral_low,
   input  logic [ADDR_WIDTH-1:0] umbral_high,
   input  logic                  err_clr,
   output logic                  rd_ok,
   output logic [DATA_WIDTH-1:0] rd_word,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH   = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   cnt;
   logic                  wr_ok;

   // A request is a single-cycle pulse; it is taken in the same cycle when
   // the channel can accept it, otherwise it is dropped and flagged. A write
   // into a full channel is still taken when a read frees a slot this cycle.
   assign full         = (cnt == DEPTH_C);
   assign empty        = (cnt == '0);
   assign rd_ok        = rd_req && !empty;
   assign wr_ok        = wr_req && (!full || rd_ok);
   assign rd_word      = mem[rd_ptr];
   assign almost_full  = (cnt >= (DEPTH_C - {1'b0, umbral_high}));
   assign almost_empty = (cnt <= {1'b0, umbral_low});

   // Storage array; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_in;
   end

   // Pointers, occupancy and sticky error bits (set wins over clear).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (!init) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
         else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
         overflow  <= (wr_req && !wr_ok) || (overflow && !err_clr);
         underflow <= (rd_req && !rd_ok) || (underflow && !err_clr);
      end
   end

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent FIFOs behind one shared write port and one
// shared read port. Decodes the VC index per request and registers the
// selected read word.
module vc_fifo_bank
   import vc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int NUM_VC     = 2,
   parameter int VC_W       = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         init,
   input  logic                         wr_enable,
   input  logic [VC_W-1:0]              wr_vc,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         rd_enable,
   input  logic [VC_W-1:0]              rd_vc,
   input  logic [NUM_VC*ADDR_WIDTH-1:0] umbral_low,
   input  logic [NUM_VC*ADDR_WIDTH-1:0] umbral_high,
   input  logic [NUM_VC-1:0]            err_clr,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         data_valid,
   output logic [NUM_VC-1:0]            full,
   output logic [NUM_VC-1:0]            empty,
   output logic [NUM_VC-1:0]            almost_full,
   output logic [NUM_VC-1:0]            almost_empty,
   output logic [NUM_VC-1:0]            overflow,
   output logic [NUM_VC-1:0]            underflow
);

   logic [NUM_VC-1:0]     rd_ok;
   logic [DATA_WIDTH-1:0] rd_words [NUM_VC];
   logic [DATA_WIDTH-1:0] rd_sel;
   logic                  rd_any;

   // An index >= NUM_VC matches no channel, so such requests vanish silently.
   for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
      vc_fifo_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_channel (
         .clk          (clk),
         .reset        (reset),
         .init         (init),
         .wr_req       (wr_enable && (wr_vc == VC_W'(i))),
         .data_in      (data_in),
         .rd_req       (rd_enable && (rd_vc == VC_W'(i))),
         .umbral_low   (umbral_low[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .umbral_high  (umbral_high[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .err_clr      (err_clr[i]),
         .rd_ok        (rd_ok[i]),
         .rd_word      (rd_words[i]),
         .full         (full[i]),
         .empty        (empty[i]),
         .almost_full  (almost_full[i]),
         .almost_empty (almost_empty[i]),
         .overflow     (overflow[i]),
         .underflow    (underflow[i])
      );
   end

   // Select the word of the channel whose read was accepted (at most one).
   always_comb begin
      rd_sel = '0;
      rd_any = |rd_ok;
      for (int i = 0; i < NUM_VC; i++) begin
         if (rd_ok[i]) rd_sel = rd_words[i];
      end
   end

   // Read output register: valid for exactly one cycle per accepted read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (!init) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_out   <= rd_any ? rd_sel : '0;
         data_valid <= rd_any;
      end
   end

endmodule
